// File: rtl/gray_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_seq_pkg
// Description : Shared types and constants for the gray-code sequencer:
//               FSM state encoding and count-direction constants.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_seq_pkg;

  // Sequencer states; encoding is fixed so other FSMs can decode it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Count direction as latched from the dir input.
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage : gray_seq_pkg
`default_nettype wire

// File: rtl/gray_core.sv
`default_nettype none
// ============================================================================
// Module      : gray_core
// Description : Binary up/down counter with a registered gray-code view.
//               The gray register is loaded from the next binary value so
//               that both update on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_core
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  output logic [WIDTH-1:0] gray
);

  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_d;

  // Next binary count: clear wins over a step; steps wrap modulo 2^WIDTH.
  always_comb begin
    b_d = b_q;
    if (clr) begin
      b_d = '0;
    end else if (en) begin
      if (dir == DIR_DN) begin
        b_d = b_q - WIDTH'(1);
      end else begin
        b_d = b_q + WIDTH'(1);
      end
    end
    gray_d = b_d ^ (b_d >> 1);
  end

  // Binary count and its gray image registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q    <= '0;
      gray_q <= '0;
    end else begin
      b_q    <= b_d;
      gray_q <= gray_d;
    end
  end

  assign gray = gray_q;

endmodule : gray_core
`default_nettype wire

// File: rtl/gray_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gray_seq_ctrl
// Description : Command-driven sequencer stepping a gray-code counter a
//               programmed number of times, with pause, abort and clear.
//               busy/step/done are registered so they line up with the
//               registered gray output.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] len,
  input  logic             pause,
  input  logic             abort,
  input  logic             clr,
  output logic [WIDTH-1:0] gray,
  output logic             busy,
  output logic             step,
  output logic             done
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_d;
  logic             dir_q;
  logic             dir_d;
  logic             busy_q;
  logic             busy_d;
  logic             step_q;
  logic             step_d;
  logic             done_q;
  logic             done_d;
  logic             core_en;
  logic             core_clr;

  // Counter datapath; only steps when the FSM commits a step this cycle.
  gray_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .en   (core_en),
    .dir  (dir_q),
    .clr  (core_clr),
    .gray (gray)
  );

  // Next-state, remaining-step bookkeeping and datapath controls.
  // Priority inside a run is abort, then pause, then step.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    core_en  = 1'b0;
    core_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        // clr and start together: the clear lands on this edge, so the
        // run's first step starts from zero.
        core_clr = clr;
        if (start) begin
          if (len != '0) begin
            state_d = RUN;
            rem_d   = len;
            dir_d   = dir;
          end else begin
            state_d = DONE;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pause) begin
          state_d = PAUSE;
        end else begin
          core_en = 1'b1;
          rem_d   = rem_q - WIDTH'(1);
          if (rem_q == WIDTH'(1)) begin
            state_d = DONE;
          end
        end
      end

      PAUSE: begin
        // Resuming costs one cycle: the step happens from RUN only.
        if (abort) begin
          state_d = IDLE;
        end else if (!pause) begin
          state_d = RUN;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == PAUSE);
    step_d = core_en;
    done_d = (state_d == DONE);
  end

  // State, latched run parameters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= DIR_UP;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign step = step_q;
  assign done = done_q;

endmodule : gray_seq_ctrl
`default_nettype wire

// File: tb/tb_gray_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_seq_ctrl
// Description : Scoreboard bench for gray_seq_ctrl: a driver pushes the
//               expected outputs from a behavioural model, a monitor pops
//               and compares them after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_seq_ctrl;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  typedef struct packed {
    logic [W-1:0] gray;
    logic         busy;
    logic         step;
    logic         done;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic [W-1:0] len = '0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] gray;
  logic         busy;
  logic         step;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t exp_q[$];

  // Behavioural model state: integer count, steps left, run flags.
  int m_b    = 0;
  int m_rem  = 0;
  bit m_dir  = 0;
  bit m_act  = 0;
  bit m_pau  = 0;
  bit m_fin  = 0;

  gray_seq_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .dir   (dir),
    .len   (len),
    .pause (pause),
    .abort (abort),
    .clr   (clr),
    .gray  (gray),
    .busy  (busy),
    .step  (step),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_b = 0; m_rem = 0; m_dir = 0; m_act = 0; m_pau = 0; m_fin = 0;
  endtask

  // One clock of the sequencer's rules, returning the outputs seen after it.
  task automatic model_step(input bit s, input bit d, input int l,
                            input bit p, input bit a, input bit c,
                            output exp_t e);
    bit stp;
    stp = 0;
    if (m_fin) begin
      m_fin = 0;
    end else if (!m_act) begin
      if (c) m_b = 0;
      if (s) begin
        if (l == 0) m_fin = 1;
        else begin
          m_act = 1; m_pau = 0; m_rem = l; m_dir = d;
        end
      end
    end else if (a) begin
      m_act = 0; m_pau = 0;
    end else if (m_pau) begin
      if (!p) m_pau = 0;
    end else if (p) begin
      m_pau = 1;
    end else begin
      m_b = m_dir ? (m_b + MOD - 1) % MOD : (m_b + 1) % MOD;
      stp = 1;
      m_rem--;
      if (m_rem == 0) begin
        m_act = 0; m_fin = 1;
      end
    end
    e.gray = W'(m_b ^ (m_b >> 1));
    e.busy = m_act;
    e.step = stp;
    e.done = m_fin;
  endtask

  // Called at a falling edge: drive inputs for the next rising edge,
  // record the expected outcome, then advance to the next falling edge.
  task automatic cyc(input bit s, input bit d, input int l,
                     input bit p, input bit a, input bit c);
    exp_t e;
    start = s; dir = d; len = W'(l); pause = p; abort = a; clr = c;
    model_step(s, d, l, p, a, c, e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares every registered output after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gray", int'(gray), int'(e.gray));
        check("busy", int'(busy), int'(e.busy));
        check("step", int'(step), int'(e.step));
        check("done", int'(done), int'(e.done));
      end
    end
  end

  initial begin
    // Reset state.
    #3;
    check("rst_gray", int'(gray), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_step", int'(step), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Up run of 5 from zero.
    cyc(1, 0, 5, 0, 0, 0);
    idle(6);
    check("up5_final_gray", int'(gray), 4'b0111);

    // Down run of 2 from zero wraps to 15 then 14.
    cyc(1, 0, 0, 0, 0, 1);
    idle(1);
    cyc(1, 1, 2, 0, 0, 0);
    idle(1);
    check("dn_first_gray", int'(gray), 4'b1000);
    idle(1);
    check("dn_second_gray", int'(gray), 4'b1001);
    check("dn_done", int'(done), 1);
    idle(2);

    // Up run of 6 from zero with a pause after the 2nd step.
    cyc(1, 0, 6, 0, 0, 1);
    idle(2);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
    idle(8);
    check("pause_final_gray", int'(gray), 4'b0101);

    // Abort after the 3rd step, then clear.
    cyc(1, 0, 8, 0, 0, 1);
    idle(3);
    cyc(0, 0, 0, 0, 1, 0);
    check("abort_gray", int'(gray), 4'b0010);
    idle(2);
    cyc(0, 0, 0, 0, 0, 1);
    check("clr_gray", int'(gray), 4'b0000);

    // Zero-length run, and start/clr/dir/len changes while busy.
    cyc(1, 0, 3, 0, 0, 0);
    idle(4);
    cyc(1, 1, 0, 0, 0, 0);
    check("len0_done", int'(done), 1);
    idle(1);
    cyc(1, 0, 6, 0, 0, 0);
    cyc(1, 1, 2, 0, 0, 1);
    cyc(1, 1, 9, 0, 0, 1);
    idle(6);

    // Asynchronous reset in the middle of a run.
    cyc(1, 0, 10, 0, 0, 0);
    idle(3);
    #2 rst = 1'b1;
    #1;
    check("midrst_gray", int'(gray), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_step", int'(step), 0);
    check("midrst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
          int'($urandom_range(0, MOD - 1)),
          $urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 5) == 0);
    end
    idle(2);
    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_gray_seq_ctrl
`default_nettype wire
